// File: rtl/ysyx_23060075_ifu_fq.sv
// Prefetching instruction fetch unit: credit-limited sequential fetch, in-order queue to IDU, redirect flush.
// Optional misaligned-redirect fault path enabled by defining YSYX_23060075_IFU_MISALIGN_CHK_EN.
module ysyx_23060075_ifu_fq #(
    parameter int              XLEN     = 32,
    parameter int              FQ_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            resp_valid,
    input  logic [XLEN-1:0] resp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_inst,
    output logic            out_fault
);

    localparam int CW  = $clog2(FQ_DEPTH + 1);
    localparam int CW1 = CW + 1;
    localparam int PW  = $clog2(FQ_DEPTH);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] STEP       = XLEN'(4);
    localparam logic [CW:0]     DEPTH_W    = CW1'(FQ_DEPTH);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
    logic [XLEN-1:0] resp_pc_reg, resp_pc_next;
    logic [CW-1:0]   inflight_reg, inflight_next;
    logic [CW-1:0]   drop_cnt_reg, drop_cnt_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;

    logic [XLEN-1:0] pc_mem   [FQ_DEPTH];
    logic [XLEN-1:0] inst_mem [FQ_DEPTH];

    logic            req_fire, resp_fire, resp_push, push_fault, push, pop;
    logic [XLEN-1:0] push_pc, push_inst, redirect_tgt;
    logic [CW:0]     credit_sum;

    assign credit_sum = {1'b0, inflight_reg} + {1'b0, count_reg};
    assign req_fire   = req_valid & req_ready;
    // A response with nothing in flight is a protocol error and is ignored.
    assign resp_fire  = resp_valid & (inflight_reg != '0);
    assign resp_push  = resp_fire & ~redirect_valid & (drop_cnt_reg == '0);
    assign push       = resp_push | push_fault;
    assign pop        = out_valid & out_ready & ~redirect_valid;
    assign push_pc    = push_fault ? fetch_pc_reg : resp_pc_reg;
    assign push_inst  = push_fault ? '0 : resp_data;

`ifdef YSYX_23060075_IFU_MISALIGN_CHK_EN
    logic misalign;
    logic fault_pend_reg;
    logic fault_mem [FQ_DEPTH];

    assign misalign     = (redirect_pc[1:0] != 2'b00);
    assign redirect_tgt = redirect_pc;
    // The fault marker waits until every older response has drained (and been dropped).
    assign push_fault   = (state_reg == FAULT) & fault_pend_reg & (inflight_reg == '0) & ~redirect_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_pend_reg <= 1'b0;
        end else if (redirect_valid) begin
            fault_pend_reg <= misalign;
        end else if (push_fault) begin
            fault_pend_reg <= 1'b0;
        end
    end
`else
    assign redirect_tgt = redirect_pc & ALIGN_MASK;
    assign push_fault   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: only a redirect can change state
    always_comb begin
        state_next = state_reg;
        if (redirect_valid) begin
`ifdef YSYX_23060075_IFU_MISALIGN_CHK_EN
            state_next = misalign ? FAULT : RUN;
`else
            state_next = RUN;
`endif
        end
    end

    // Output logic
    always_comb begin
        req_valid = fetch_en & ~rst & ~redirect_valid & (state_reg == RUN) & (credit_sum < DEPTH_W);
        req_addr  = fetch_pc_reg & ALIGN_MASK;
        out_valid = (count_reg != '0);
        out_pc    = '0;
        out_inst  = '0;
        out_fault = 1'b0;
        if (out_valid) begin
            out_pc   = pc_mem[rd_ptr_reg];
            out_inst = inst_mem[rd_ptr_reg];
`ifdef YSYX_23060075_IFU_MISALIGN_CHK_EN
            out_fault = fault_mem[rd_ptr_reg];
`endif
        end
    end

    // Counters, pointers and fetch/response PCs
    always_comb begin
        inflight_next = inflight_reg + CW'(req_fire) - CW'(resp_fire);
        drop_cnt_next = drop_cnt_reg;
        fetch_pc_next = fetch_pc_reg;
        resp_pc_next  = resp_pc_reg;
        count_next    = count_reg;
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        if (redirect_valid) begin
            // Everything still outstanding after this cycle belongs to the old stream.
            drop_cnt_next = inflight_next;
            fetch_pc_next = redirect_tgt;
            resp_pc_next  = redirect_tgt;
            count_next    = '0;
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
        end else begin
            if (resp_fire && (drop_cnt_reg != '0)) drop_cnt_next = drop_cnt_reg - CW'(1);
            if (req_fire)  fetch_pc_next = fetch_pc_reg + STEP;
            if (resp_push) resp_pc_next  = resp_pc_reg + STEP;
            count_next = count_reg + CW'(push) - CW'(pop);
            if (push) wr_ptr_next = wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_next = rd_ptr_reg + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_reg <= RESET_PC;
            resp_pc_reg  <= RESET_PC;
            inflight_reg <= '0;
            drop_cnt_reg <= '0;
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            resp_pc_reg  <= resp_pc_next;
            inflight_reg <= inflight_next;
            drop_cnt_reg <= drop_cnt_next;
            count_reg    <= count_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
        end
    end

    // Queue storage; contents need no reset since count gates visibility
    for (genvar gi = 0; gi < FQ_DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push && (wr_ptr_reg == PW'(gi))) begin
                pc_mem[gi]   <= push_pc;
                inst_mem[gi] <= push_inst;
`ifdef YSYX_23060075_IFU_MISALIGN_CHK_EN
                fault_mem[gi] <= push_fault;
`endif
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && resp_valid && (inflight_reg == '0)) begin
            $error("ifu_fq: resp_valid with no request in flight");
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_23060075_ifu_fq.sv
// Scoreboard bench for ysyx_23060075_ifu_fq: request monitor pushes expected outputs, output monitor pops and compares.
module tb_ysyx_23060075_ifu_fq;

    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst, fetch_en, redirect_valid;
    logic [31:0] redirect_pc;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_inst;
    logic        out_fault;

    ysyx_23060075_ifu_fq dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_fault(out_fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];
    int          tests = 0, fails = 0;
    int          req_fires = 0, out_cnt = 0, resp_cnt = 0, cyc = 0, lat = 1;
    int          mark_cnt = -1, red_resp_base = 0, base;
    logic [31:0] mark_pc = 32'hDEAD_BEEF;
    logic [31:0] exp_req_pc = RPC;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Request monitor: checks address order and records the expected returned entry.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && req_valid && req_ready) begin
            check("req_addr", req_addr, exp_req_pc);
            e.pc = exp_req_pc;
            e.inst = mem_word(exp_req_pc);
            e.fault = 1'b0;
            exp_q.push_back(e);
            mem_addr_q.push_back(req_addr);
            mem_due_q.push_back(cyc + lat);
            exp_req_pc += 32'd4;
            req_fires++;
        end
    end

    // Memory model: in-order responses, `lat` cycles after the handshake, reset by the same rst.
    initial begin
        resp_valid = 1'b0;
        resp_data  = '0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mem_addr_q.delete();
                mem_due_q.delete();
                resp_valid = 1'b0;
                resp_data  = '0;
            end else begin
                #1;
                cyc++;
                if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
                    resp_valid = 1'b1;
                    resp_data  = mem_word(mem_addr_q.pop_front());
                    void'(mem_due_q.pop_front());
                    resp_cnt++;
                end else begin
                    resp_valid = 1'b0;
                end
            end
        end
    end

    // Output monitor: a pop is a transaction unless a redirect is present that cycle.
    initial forever begin
        @(negedge clk);
        if (!rst && out_valid && out_ready && !redirect_valid) begin
            tests++;
            if (out_cnt == mark_cnt) mark_pc = out_pc;
            out_cnt++;
            $display("[TB] out pc=%h inst=%h fault=%b", out_pc, out_inst, out_fault);
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL out_unexpected: got pc=%h inst=%h, required no output", out_pc, out_inst);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_pc !== mon_e.pc || out_inst !== mon_e.inst || out_fault !== mon_e.fault) begin
                    fails++;
                    $display("FAIL out_entry: got pc=%h inst=%h fault=%b required pc=%h inst=%h fault=%b",
                             out_pc, out_inst, out_fault, mon_e.pc, mon_e.inst, mon_e.fault);
                end
            end
        end
    end

    task automatic do_reset;
        rst = 1'b1;
        fetch_en = 1'b0;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        exp_q.delete();
        exp_req_pc = RPC;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        fetch_en = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 300 && (exp_q.size() != 0 || mem_addr_q.size() != 0); i++) tick(1);
        tick(4);
        check({name, "_left"}, exp_q.size(), 0);
        check({name, "_out_valid"}, out_valid, 0);
    endtask

    // Called just after a rising edge; leaves the bench at the falling edge of the cycle after the redirect.
    task automatic redirect(input logic [31:0] pc);
        exp_t e;
        redirect_valid = 1'b1;
        redirect_pc = pc;
        exp_q.delete();
`ifdef YSYX_23060075_IFU_MISALIGN_CHK_EN
        if (pc[1:0] != 2'b00) begin
            e.pc = pc;
            e.inst = '0;
            e.fault = 1'b1;
            exp_q.push_back(e);
        end
        exp_req_pc = pc;
`else
        exp_req_pc = pc & 32'hFFFF_FFFC;
`endif
        mark_pc = 32'hDEAD_BEEF;
        @(negedge clk);
        check("redir_req_valid", req_valid, 0);
        red_resp_base = resp_cnt;
        mark_cnt = out_cnt;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        check("redir_flush", out_valid, 0);
    endtask

    task automatic check_first(input string name, input logic [31:0] exp);
        for (int i = 0; i < 100 && out_cnt <= mark_cnt; i++) tick(1);
        check(name, mark_pc, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; fetch_en = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        req_ready = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("rst_req_valid", req_valid, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_inst", out_inst, 0);
        check("rst_out_fault", out_fault, 0);
        check("rst_req_addr", req_addr, RPC);
        tick(1);

        // Streaming with a 1-cycle memory: one output per cycle once warmed up
        rst = 1'b0; lat = 1; out_ready = 1'b1; fetch_en = 1'b1;
        tick(6);
        base = out_cnt;
        tick(20);
        check("t1_no_gaps", out_cnt - base, 20);
        drain("t1");

        // Back-pressure: credits cap requests at the queue depth
        do_reset();
        lat = 1; fetch_en = 1'b1;
        base = req_fires;
        tick(12);
        check("t2_req_count", req_fires - base, 4);
        check("t2_req_valid_off", req_valid, 0);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        tick(10);
        check("t2_one_pop_one_req", req_fires - base, 5);
        drain("t2");

        // Redirect with three requests in flight
        do_reset();
        lat = 8; out_ready = 1'b1; fetch_en = 1'b1;
        base = req_fires;
        for (int i = 0; i < 50 && req_fires < base + 3; i++) tick(1);
        fetch_en = 1'b1;
        check("t3_issued", req_fires - base, 3);
        redirect(32'h8000_1000);
        check_first("t3_first_pc", 32'h8000_1000);
        tick(10);
        drain("t3");
        check("t3_dropped", (resp_cnt - red_resp_base) - (out_cnt - mark_cnt), 3);

        // Redirect in the same cycle as a response
        do_reset();
        lat = 1; out_ready = 1'b1; fetch_en = 1'b1;
        tick(8);
        check("t4_resp_present", resp_valid, 1);
        redirect(32'h8000_2040);
        check_first("t4_first_pc", 32'h8000_2040);
        tick(10);
        drain("t4");
        check("t4_dropped", (resp_cnt - red_resp_base) - (out_cnt - mark_cnt), 0);

        // Asynchronous reset between edges mid-burst
        do_reset();
        lat = 1; out_ready = 1'b1; fetch_en = 1'b1;
        tick(7);
        #2;
        rst = 1'b1;
        exp_q.delete();
        exp_req_pc = RPC;
        #1;
        check("t5_out_valid", out_valid, 0);
        check("t5_req_valid", req_valid, 0);
        check("t5_out_pc", out_pc, 0);
        check("t5_out_inst", out_inst, 0);
        check("t5_out_fault", out_fault, 0);
        tick(2);
        mark_cnt = out_cnt;
        mark_pc = 32'hDEAD_BEEF;
        rst = 1'b0;
        check_first("t5_restart_pc", RPC);
        tick(5);
        drain("t5");

        // Misaligned redirect target
        do_reset();
        lat = 4; out_ready = 1'b1; fetch_en = 1'b1;
        tick(3);
`ifdef YSYX_23060075_IFU_MISALIGN_CHK_EN
        redirect(32'h8000_0002);
        base = req_fires;
        check_first("t6_fault_pc", 32'h8000_0002);
        tick(12);
        check("t6_no_req", req_fires - base, 0);
        check("t6_fault_left", exp_q.size(), 0);
        tick(1);
        redirect(32'h8000_0010);
        check_first("t6_resume_pc", 32'h8000_0010);
`else
        redirect(32'h8000_0102);
        check_first("t6_masked_pc", 32'h8000_0100);
`endif
        tick(6);
        drain("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
